wb_uart_port: RTL

// - 32-bit Wishbone B4 classic responder on the narrow I/O bus (behind the 128->32 adapter) that bridges CPU

---
 rtl/wb_uart_port.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_uart_port.sv
// Wishbone B4 classic responder bridging CPU register accesses to UART TX/RX byte streams.
// Each direction is buffered by a FIFO of 2**FIFO_DEPTH_LOG2 bytes.
module wb_uart_port #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_RSVD2  = 2'd2,
    REG_RSVD3  = 2'd3
  } reg_e;

  reg_e reg_sel;
  logic accept;
  logic [31:0] rdata;
  logic txdrop;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [AW:0]   tx_cnt;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_drop_evt;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [AW:0]   rx_cnt;
  logic          rx_empty, rx_full, rx_push, rx_pop;

  logic unused_bits;
  assign unused_bits = ^{adr_i[1:0], sel_i[3:1], dat_i[31:8]};

  assign reg_sel = reg_e'(adr_i[3:2]);
  // Blocking acceptance while ack_o is high guarantees single-shot side effects.
  assign accept  = cyc_i & stb_i & ~ack_o;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd];
  assign rx_ready = ~rx_full & ~rst;

  // Full/empty come from pre-edge counts, so same-edge stream activity never rescues a CPU access.
  assign tx_push     = accept & we_i & (reg_sel == REG_DATA) & sel_i[0] & ~tx_full;
  assign tx_drop_evt = accept & we_i & (reg_sel == REG_DATA) & sel_i[0] & tx_full;
  assign tx_pop      = tx_valid & tx_ready;
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop      = accept & ~we_i & (reg_sel == REG_DATA) & ~rx_empty;

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_DATA: begin
        if (!rx_empty) rdata = {23'b0, 1'b1, rx_mem[rx_rd]};
      end
      REG_STATUS: begin
        rdata = {8'b0, 8'(tx_cnt), 8'(rx_cnt), 3'b0, txdrop, 1'b0,
                 tx_empty, ~tx_full, ~rx_empty};
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= dat_i[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o  <= 1'b0;
      dat_o  <= '0;
      txdrop <= 1'b0;
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      ack_o <= accept;
      dat_o <= (accept && !we_i) ? rdata : '0;

      if (tx_drop_evt)
        txdrop <= 1'b1;
      else if (accept && we_i && reg_sel == REG_STATUS && sel_i[0] && dat_i[4])
        txdrop <= 1'b0;

      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase

      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

endmodule
